pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the fetch front end. It replaces the fixed 32-bit, always-advance PC register with the following features:
- configurable width, reset vector and instruction step;
- a cycles-per-instruction pacing counter for multi-cycle cores;
- stall and fetch-ready back-pressure;
- prioritised redirect (branch/jump) with a pending-redirect buffer.

It sits between the branch/execute stage, which supplies `redirect`, and instruction memory, which consumes `pc`.

## Interface
Parameters:
- `XLEN`, 32: PC width in bits.
- `RESET_VEC`, 32'h0000_0000: PC value after reset.
- `TRAP_VEC`, 32'h0000_0100: target for a misaligned redirect (used only with the macro).
- `ALIGN`, 2: log2 of the instruction size in bytes. Step is `1<<ALIGN`.
- `CPI`, 1: cycles per PC advance. Legal range is 1..8.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `stall`  in  1: freezes the PC and the pacing counter.
- `fetch_ready`  in  1: fetch can accept a new PC this cycle.
- `redirect`  in  1: single-cycle request to load `redirect_pc`.
- `redirect_pc`  in  XLEN: redirect target.
- `pc`  out  XLEN: current fetch address.
- `pc_valid`  out  1: `pc` is valid for fetch.
- `next_iter`  out  1: one-cycle pulse marking the cycle a new PC is presented.
- `misalign`  out  1: one-cycle pulse on a trapped misaligned redirect.
- `bad_addr`  out  XLEN: offending redirect target, held until the next trap.

## Operation
States:
- `BOOT`: entered on reset. Exits to `RUN` on the first clock edge after `rst` falls. Never re-entered except by reset.
- `RUN`: normal operation.

Reset values: `pc`=RESET_VEC, `pc_valid`=0, `next_iter`=0, `misalign`=0, `bad_addr`=0, pace counter `cnt`=0, pending redirect cleared.

`BOOT`→`RUN` transition:
- `pc` stays RESET_VEC.
- `pc_valid`←1.
- `next_iter` pulses once.

Pace counter `cnt` (width `$clog2(CPI)`, minimum 1 bit):
- Increments each cycle in `RUN` when `!stall`.
- Saturates at CPI-1.
- Clears to 0 on an advance.

Advance condition, evaluated in `RUN`: `cnt==CPI-1 && fetch_ready && !stall`.

On an advance, the next PC is chosen by priority:
1. Live `redirect` this cycle.
2. Pending redirect.
3. `pc + (1<<ALIGN)`, modulo 2^XLEN. Wraps silently from the all-ones aligned address to 0.

Also on an advance: `next_iter` pulses for one cycle, and the pending redirect is cleared.

Redirect not coincident with an advance:
- `redirect_pc` is latched into the pending register.
- A later redirect overwrites an earlier pending one (last wins).

Redirect in `BOOT`: latched as pending and applied at the first advance.

Alignment: without the macro, the low `ALIGN` bits of any redirect target are forced to 0.

`stall` dominates `fetch_ready`. While stalled, `pc`, `cnt` and `pc_valid` hold, and redirects still latch as pending.

## Timing
- `pc` changes only on a rising edge following an advance condition, so the new value is visible one cycle after the advance condition.
- CPI=1 with `fetch_ready`=1 and no stall: a new PC every cycle.
- CPI=N: at least N cycles between PC changes.
- Redirect-to-PC latency is 1 cycle when the redirect coincides with an advance. Otherwise the PC changes at the next advance.
- `next_iter` is registered and aligned with the new `pc` value.
- Asserting `rst` mid-operation immediately forces all reset values without waiting for a clock, and discards any pending redirect.

## Configuration
Macro: `PC_MISALIGN_CHECK_EN`.

Defined:
- A redirect target with nonzero low `ALIGN` bits is not masked.
- On its advance: `pc`←TRAP_VEC, `misalign` pulses, and `bad_addr`←the raw target.
- The check applies to both live and pending redirects.

Undefined:
- Targets are masked.
- `misalign` is tied to 0 and `bad_addr` is tied to 0.
- TRAP_VEC is unused.

## Structure
Shared package `pc_pkg` holds:
- the `pc_state_e` enum (`BOOT`, `RUN`);
- default constants `PC_RESET_VEC` and `PC_TRAP_VEC`;
- `pc_step(align)`, a localparam-style function.

One sub-module, `pc_pace_cnt`:
- a saturating CPI counter with `clk`, `rst`, `en`, `clr` inputs and a `done` output;
- instantiated once.

## Test plan
- Reset then release, CPI=1, `fetch_ready`=1 → `pc` is 0x0 for 2 cycles (`BOOT` + first `RUN`), then 0x4, 0x8, 0xC; `next_iter` is high each cycle after `BOOT`.
- CPI=5, no stall → `pc` steps 0x0→0x4→0x8 exactly every 5 cycles; `next_iter` pulses once per step.
- `stall` held 3 cycles with `redirect_pc`=0x40 pulsed during the stall → `pc` is frozen during the stall, then becomes 0x40 on the first advance after the stall; a second redirect to 0x80 issued before that advance wins instead.
- `pc`=0xFFFF_FFFC with XLEN=32 advancing → `pc`=0x0000_0000, no error.
- Redirect to 0x42 → without the macro, `pc`=0x40; with `PC_MISALIGN_CHECK_EN`, `pc`=0x100, `misalign` pulses 1 cycle, `bad_addr`=0x42.
- `rst` asserted mid-run with a pending redirect → `pc`=RESET_VEC and `pc_valid`=0 without waiting for a clock edge; after release, the pending target is never taken.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch program-counter generator.
// Holds the FSM state enum, default vectors and the step helper.
package pc_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } pc_state_e;

    localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] PC_TRAP_VEC  = 32'h0000_0100;

    function automatic int unsigned pc_step(input int unsigned align);
        return 32'd1 << align;
    endfunction

endpackage

// File: rtl/pc_pace_cnt.sv
// Saturating cycles-per-instruction pacing counter.
// Ports: clk, rst (async, active-high), en (count), clr (restart), done (at CPI-1).
module pc_pace_cnt
    import pc_pkg::*;
#(
    parameter int unsigned CPI = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic done
);

    localparam int unsigned CW = (CPI > 1) ? $clog2(CPI) : 1;
    localparam logic [CW-1:0] LAST = CW'(CPI - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == LAST);

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: paced advance, stall/back-pressure, prioritised redirect.
// Ports: clk, rst, stall, fetch_ready, redirect, redirect_pc -> pc, pc_valid,
//        next_iter, misalign, bad_addr. Macro PC_MISALIGN_CHECK_EN enables trapping
//        of misaligned redirect targets instead of masking them.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(PC_RESET_VEC),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(PC_TRAP_VEC),
    parameter int unsigned     ALIGN     = 2,
    parameter int unsigned     CPI       = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            fetch_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            next_iter,
    output logic            misalign,
    output logic [XLEN-1:0] bad_addr
);

    localparam logic [XLEN-1:0] STEP = XLEN'(pc_step(ALIGN));
    localparam logic [XLEN-1:0] LOW  = STEP - XLEN'(1);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            iter_q, iter_d;
    logic            pend_vld_q, pend_vld_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;

    logic            run;
    logic            done;
    logic            adv;
    logic            take;
    logic [XLEN-1:0] pend_in;
    logic [XLEN-1:0] tgt;

    assign run  = (state_q == RUN);
    assign adv  = run && done && fetch_ready && !stall;
    assign take = redirect || pend_vld_q;

    pc_pace_cnt #(
        .CPI (CPI)
    ) u_pace (
        .clk  (clk),
        .rst  (rst),
        .en   (run && !stall),
        .clr  (adv),
        .done (done)
    );

`ifdef PC_MISALIGN_CHECK_EN
    // Raw targets are kept so a misaligned one can be reported.
    logic            mis_q, mis_d;
    logic [XLEN-1:0] bad_q, bad_d;

    assign pend_in = redirect_pc;
`else
    assign pend_in = redirect_pc & ~LOW;
`endif

    // Live redirect outranks the pending one.
    assign tgt = redirect ? pend_in : pend_pc_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        iter_d     = 1'b0;
        pend_vld_d = pend_vld_q;
        pend_pc_d  = pend_pc_q;
`ifdef PC_MISALIGN_CHECK_EN
        mis_d      = 1'b0;
        bad_d      = bad_q;
`endif
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
                valid_d = 1'b1;
                iter_d  = 1'b1;
            end
            RUN: begin
                if (adv) begin
                    iter_d     = 1'b1;
                    pend_vld_d = 1'b0;
                    if (take) begin
                        pc_d = tgt;
`ifdef PC_MISALIGN_CHECK_EN
                        if ((tgt & LOW) != '0) begin
                            pc_d  = TRAP_VEC;
                            mis_d = 1'b1;
                            bad_d = tgt;
                        end
`endif
                    end else begin
                        pc_d = pc_q + STEP;
                    end
                end
            end
        endcase
        // A redirect that misses an advance waits; the newest one wins.
        if (redirect && !adv) begin
            pend_vld_d = 1'b1;
            pend_pc_d  = pend_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VEC;
            valid_q    <= 1'b0;
            iter_q     <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_pc_q  <= '0;
`ifdef PC_MISALIGN_CHECK_EN
            mis_q      <= 1'b0;
            bad_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            iter_q     <= iter_d;
            pend_vld_q <= pend_vld_d;
            pend_pc_q  <= pend_pc_d;
`ifdef PC_MISALIGN_CHECK_EN
            mis_q      <= mis_d;
            bad_q      <= bad_d;
`endif
        end
    end

    assign pc        = pc_q;
    assign pc_valid  = valid_q;
    assign next_iter = iter_q;

`ifdef PC_MISALIGN_CHECK_EN
    assign misalign = mis_q;
    assign bad_addr = bad_q;
`else
    logic unused_trap;
    assign unused_trap = ^TRAP_VEC;
    assign misalign    = 1'b0;
    assign bad_addr    = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (CPI=1 and CPI=5 instances).
// Expected values are hand-computed; honours PC_MISALIGN_CHECK_EN.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        fetch_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic        pc_valid;
    logic        next_iter;
    logic        misalign;
    logic [31:0] bad_addr;

    logic [31:0] pc5;
    logic        pc_valid5;
    logic        next_iter5;
    logic        misalign5;
    logic [31:0] bad_addr5;

    int n_chk;
    int n_err;

    pc_gen #(.XLEN(32), .CPI(1)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .fetch_ready (fetch_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .next_iter   (next_iter),
        .misalign    (misalign),
        .bad_addr    (bad_addr)
    );

    pc_gen #(.XLEN(32), .CPI(5)) u_dut5 (
        .clk         (clk),
        .rst         (rst),
        .stall       (1'b0),
        .fetch_ready (1'b1),
        .redirect    (1'b0),
        .redirect_pc (32'h0),
        .pc          (pc5),
        .pc_valid    (pc_valid5),
        .next_iter   (next_iter5),
        .misalign    (misalign5),
        .bad_addr    (bad_addr5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] t_pc1 [11];
    logic [31:0] t_pc5 [11];
    logic        t_ni5 [11];

    initial begin
        n_chk = 0;
        n_err = 0;
        t_pc1 = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14,
                  32'h18, 32'h1C, 32'h20, 32'h24, 32'h28};
        t_pc5 = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4,
                  32'h4, 32'h4, 32'h4, 32'h4, 32'h8};
        t_ni5 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst         = 1'b1;
        stall       = 1'b0;
        fetch_ready = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        #3;
        check("rst_pc", pc, 32'h0);
        check("rst_valid", {31'b0, pc_valid}, 32'h0);
        check("rst_iter", {31'b0, next_iter}, 32'h0);
        check("rst_mis", {31'b0, misalign}, 32'h0);
        check("rst_bad", bad_addr, 32'h0);
        step();
        rst = 1'b0;

        for (int k = 0; k < 11; k++) begin
            step();
            check($sformatf("cpi1_pc%0d", k), pc, t_pc1[k]);
            check($sformatf("cpi1_ni%0d", k), {31'b0, next_iter}, 32'h1);
            check($sformatf("cpi5_pc%0d", k), pc5, t_pc5[k]);
            check($sformatf("cpi5_ni%0d", k), {31'b0, next_iter5},
                  {31'b0, t_ni5[k]});
        end
        check("boot_valid", {31'b0, pc_valid}, 32'h1);

        // stall 3 cycles, redirect to 0x40 during the stall
        stall = 1'b1;
        step();
        check("stall_pc_a", pc, 32'h28);
        check("stall_ni_a", {31'b0, next_iter}, 32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        step();
        check("stall_pc_b", pc, 32'h28);
        redirect = 1'b0;
        step();
        check("stall_pc_c", pc, 32'h28);
        check("stall_valid", {31'b0, pc_valid}, 32'h1);
        stall = 1'b0;
        step();
        check("pend_pc", pc, 32'h40);
        check("pend_ni", {31'b0, next_iter}, 32'h1);

        // two pending redirects, last one wins
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h60;
        step();
        redirect_pc = 32'h80;
        step();
        redirect = 1'b0;
        step();
        check("last_hold", pc, 32'h40);
        stall = 1'b0;
        step();
        check("last_wins", pc, 32'h80);

        // live redirect with advance, then wrap
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        check("live_pc", pc, 32'hFFFF_FFFC);
        redirect = 1'b0;
        step();
        check("wrap_pc", pc, 32'h0);
        check("wrap_mis", {31'b0, misalign}, 32'h0);

        // back-pressure
        fetch_ready = 1'b0;
        step();
        check("fr_hold", pc, 32'h0);
        check("fr_ni", {31'b0, next_iter}, 32'h0);
        fetch_ready = 1'b1;
        step();
        check("fr_go", pc, 32'h4);

        // misaligned live redirect
        redirect    = 1'b1;
        redirect_pc = 32'h42;
        step();
`ifdef PC_MISALIGN_CHECK_EN
        check("mis_pc", pc, 32'h100);
        check("mis_pulse", {31'b0, misalign}, 32'h1);
        check("mis_bad", bad_addr, 32'h42);
`else
        check("mis_pc", pc, 32'h40);
        check("mis_pulse", {31'b0, misalign}, 32'h0);
        check("mis_bad", bad_addr, 32'h0);
`endif
        redirect = 1'b0;
        step();
`ifdef PC_MISALIGN_CHECK_EN
        check("mis_next", pc, 32'h104);
        check("mis_clr", {31'b0, misalign}, 32'h0);
        check("mis_held", bad_addr, 32'h42);
`else
        check("mis_next", pc, 32'h44);
        check("mis_clr", {31'b0, misalign}, 32'h0);
`endif

        // misaligned pending redirect
        fetch_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h23;
        step();
        redirect    = 1'b0;
        fetch_ready = 1'b1;
        step();
`ifdef PC_MISALIGN_CHECK_EN
        check("pmis_pc", pc, 32'h100);
        check("pmis_pulse", {31'b0, misalign}, 32'h1);
        check("pmis_bad", bad_addr, 32'h23);
`else
        check("pmis_pc", pc, 32'h20);
`endif

        // async reset with a pending redirect
        fetch_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_pc", pc, 32'h0);
        check("arst_valid", {31'b0, pc_valid}, 32'h0);
        check("arst_pc5", pc5, 32'h0);
        #1;
        rst         = 1'b0;
        fetch_ready = 1'b1;
        step();
        check("rboot_pc", pc, 32'h0);
        check("rboot_valid", {31'b0, pc_valid}, 32'h1);
        step();
        check("no_stale", pc, 32'h4);
        step();
        check("no_stale2", pc, 32'h8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
